// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants and the fetch-queue entry type.
package cpu_pkg;
    localparam int FQ_DEPTH = 4;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] TEXT_BASE = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr} prefetch buffer between fetch and decode, with flush on redirect.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PTR_W:0]     count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop;

    always_comb begin
        in_ready  = cnt_q != FULL;
        out_valid = cnt_q != '0;
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        wr_ptr_d  = flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        cnt_d     = flush ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset; out_valid gates what decode sees.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
    end

    always_comb begin
        out_pc    = out_valid ? mem_q[rd_ptr_q].pc : '0;
        out_instr = out_valid ? mem_q[rd_ptr_q].instr : NOP_INSTR;
        count     = cnt_q;
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt_q <= FULL);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fill, drain, wrap, flush, backpressure and async reset.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0, out_pc, out_instr;
    logic [2:0]  count;
    int          checks = 0, failures = 0;
    logic [31:0] held_instr;

    fetch_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        reset = 1'b0;
        step();
        chk("idle_out_valid", 32'(out_valid), 0);

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = TEXT_BASE + 32'(4 * i);
            in_instr = 32'h2401_0001 + 32'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_head_pc", out_pc, 32'h3000);
        end
        chk("full_in_ready", 32'(in_ready), 0);
        in_pc = 32'h3010;
        step();
        chk("full_ignore_count", 32'(count), 4);
        chk("full_ignore_pc", out_pc, 32'h3000);
        in_valid = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 32'h3000 + 32'(4 * i));
            chk("drain_instr", out_instr, 32'h2401_0001 + 32'(i));
            step();
            if (i == 0) chk("drain_ready_after_full", 32'(in_ready), 1);
        end
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_count", 32'(count), 0);
        chk("empty_out_instr", out_instr, 0);
        out_ready = 1'b0;

        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc    = 32'h3100 + 32'(4 * i);
            in_instr = {16'h2401, in_pc[15:0]};
            step();
        end
        chk("pp_pre_count", 32'(count), 2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc    = 32'h3108 + 32'(4 * k);
            in_instr = {16'h2401, in_pc[15:0]};
            chk("pp_out_pc", out_pc, 32'h3100 + 32'(4 * k));
            step();
            chk("pp_count", 32'(count), 2);
        end
        chk("pp_post_pc", out_pc, 32'h3128);
        out_ready = 1'b0;
        in_pc     = 32'h3130;
        in_instr  = 32'h2401_3130;
        step();
        chk("pre_flush_count", 32'(count), 3);

        flush = 1'b1;
        in_pc = 32'h3040;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_out_pc", out_pc, 0);
        in_valid = 1'b1;
        in_pc    = 32'h3080;
        in_instr = 32'h2401_3080;
        step();
        chk("post_flush_pc", out_pc, 32'h3080);
        chk("post_flush_count", 32'(count), 1);

        held_instr = 32'h2401_3080;
        for (int k = 0; k < 5; k++) begin
            in_pc    = 32'h3084 + 32'(4 * k);
            in_instr = {16'h2401, in_pc[15:0]};
            step();
            chk("bp_out_pc", out_pc, 32'h3080);
            chk("bp_out_instr", out_instr, held_instr);
            chk("bp_count", 32'(count), (k + 2 > 4) ? 4 : 32'(k + 2));
            chk("bp_in_ready", 32'(in_ready), (k + 2 >= 4) ? 0 : 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mid_count", 32'(count), 3);
        chk("mid_pc", out_pc, 32'h3084);

        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_out_instr", out_instr, 0);
        #1;
        reset = 1'b0;
        step();
        chk("after_rst_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
